// File: rtl/bus_mem_responder.sv
// -----------------------------------------------------------------------------
// bus_mem_responder
//
// Memory-side responder for the 64-bit request/response system bus. It accepts
// one line-sized transaction at a time, performs 8-beat line reads and writes
// against an internal word array, and returns read data with its tag after a
// fixed LATENCY.
//
// Optional feature macro: BUS_MEM_CRITICAL_WORD_FIRST_EN
//   defined   : read beats start at the requested word (addr[5:3]) and wrap
//               within the line.
//   undefined : read beats always start at word 0 of the line.
//
// Parameters
//   BUS_DATA_WIDTH : bus data/address width (64 only)
//   BUS_TAG_WIDTH  : tag width; MSB = read(1)/write(0), rest echoed back
//   MEM_WORDS      : number of 64-bit words, power of two, at least 8
//   LATENCY        : idle cycles between address ack and first read beat (>=1)
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-low
//   bus_reqcyc   in   request valid (address phase or write beat)
//   bus_req      in   byte address (address phase) / write data (beats)
//   bus_reqtag   in   tag, sampled in the address phase only
//   bus_reqack   out  one-cycle address ack, or level write-beat ready
//   bus_respcyc  out  read beat valid
//   bus_resp     out  read beat data
//   bus_resptag  out  tag of the current read transaction
//   bus_respack  in   initiator consumed the current read beat
//
// Handshake: an address is taken on any IDLE edge with bus_reqcyc=1. A write
// beat transfers on an edge with bus_reqcyc=1 && bus_reqack=1. A read beat
// transfers on an edge with bus_respcyc=1 && bus_respack=1; until then
// bus_resp and bus_resptag are held stable.
// -----------------------------------------------------------------------------
module bus_mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 4096,
    parameter int LATENCY        = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK,
        ST_WAIT,
        ST_RESP,
        ST_WDATA
    } state_t;

    // FSM state is kept as a named signal so checkers can bind to it.
    state_t                     state;
    logic [BUS_DATA_WIDTH-1:0]  mem [MEM_WORDS];

    logic [AW-1:0]              line_base;   // word index of the line, low 3 bits zero
    logic [2:0]                 start_off;   // first read word within the line
    logic [2:0]                 beat;        // beat counter for reads and writes
    logic [CW-1:0]              wait_cnt;
    logic [BUS_TAG_WIDTH-1:0]   tag_q;
    logic                       is_read;

    // Combinational helpers
    logic [AW-1:0]              req_idx;
    logic [2:0]                 next_off;
    logic [AW-1:0]              first_rd_addr;
    logic [AW-1:0]              next_rd_addr;
    logic [AW-1:0]              wr_addr;
    logic                       mem_we;

    always_comb begin
        // Upper address bits beyond the array are dropped, so addresses wrap.
        req_idx       = bus_req[3 +: AW];
        next_off      = start_off + beat + 3'd1;
        first_rd_addr = line_base | AW'(start_off);
        next_rd_addr  = line_base | AW'(next_off);
        wr_addr       = line_base | AW'(beat);
        // A write beat never lands on a reset edge: aborted beats are dropped.
        mem_we        = reset && (state == ST_WDATA) && bus_reqcyc && bus_reqack;
    end

    // Array is not reset; contents survive an aborted transaction.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr] <= bus_req;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            bus_reqack  <= 1'b0;
            bus_respcyc <= 1'b0;
            bus_resp    <= '0;
            bus_resptag <= '0;
            line_base   <= '0;
            start_off   <= '0;
            beat        <= '0;
            wait_cnt    <= '0;
            tag_q       <= '0;
            is_read     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus_reqcyc) begin
                        line_base  <= req_idx & ~AW'(7);
                        tag_q      <= bus_reqtag;
                        is_read    <= bus_reqtag[BUS_TAG_WIDTH-1];
`ifdef BUS_MEM_CRITICAL_WORD_FIRST_EN
                        start_off  <= req_idx[2:0];
`else
                        start_off  <= 3'd0;
`endif
                        beat       <= 3'd0;
                        bus_reqack <= 1'b1;
                        state      <= ST_ACK;
                    end
                end

                ST_ACK: begin
                    if (is_read) begin
                        bus_reqack <= 1'b0;
                        wait_cnt   <= '0;
                        state      <= ST_WAIT;
                    end else begin
                        // Ack stays high as the write-beat ready level.
                        bus_reqack <= 1'b1;
                        beat       <= 3'd0;
                        state      <= ST_WDATA;
                    end
                end

                ST_WAIT: begin
                    if (wait_cnt == CW'(LATENCY - 1)) begin
                        wait_cnt    <= '0;
                        beat        <= 3'd0;
                        bus_respcyc <= 1'b1;
                        bus_resp    <= mem[first_rd_addr];
                        bus_resptag <= tag_q;
                        state       <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end

                ST_RESP: begin
                    if (bus_respack) begin
                        if (beat == 3'd7) begin
                            beat        <= 3'd0;
                            bus_respcyc <= 1'b0;
                            bus_resp    <= '0;
                            bus_resptag <= '0;
                            state       <= ST_IDLE;
                        end else begin
                            beat     <= beat + 3'd1;
                            bus_resp <= mem[next_rd_addr];
                        end
                    end
                end

                ST_WDATA: begin
                    if (bus_reqcyc) begin
                        if (beat == 3'd7) begin
                            beat       <= 3'd0;
                            bus_reqack <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            beat <= beat + 3'd1;
                        end
                    end
                end

                default: begin
                    state       <= ST_IDLE;
                    bus_reqack  <= 1'b0;
                    bus_respcyc <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_bus_mem_responder
//
// Bench for bus_mem_responder: clock/reset block, driver tasks for line writes
// and line reads, a word-level memory model plus an expected-beat queue, and a
// final summary line. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_bus_mem_responder;

    localparam int DW  = 64;
    localparam int TW  = 13;
    localparam int MW  = 4096;
    localparam int LAT = 4;

    logic          clk;
    logic          reset;
    logic          bus_reqcyc;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_reqack;
    logic          bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;
    logic          bus_respack;

    int            n_checks;
    int            n_errors;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_mem [int];

    bus_mem_responder #(
        .BUS_DATA_WIDTH(DW),
        .BUS_TAG_WIDTH (TW),
        .MEM_WORDS     (MW),
        .LATENCY       (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_reqcyc (bus_reqcyc),
        .bus_req    (bus_req),
        .bus_reqtag (bus_reqtag),
        .bus_reqack (bus_reqack),
        .bus_respcyc(bus_respcyc),
        .bus_resp   (bus_resp),
        .bus_resptag(bus_resptag),
        .bus_respack(bus_respack)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_rd(input int idx);
        if (model_mem.exists(idx)) return model_mem[idx];
        return 64'd0;
    endfunction

    function automatic int line_base_of(input logic [63:0] addr);
        int idx;
        idx = int'((addr >> 3) & 64'(MW - 1));
        return idx & ~7;
    endfunction

    // Called at a falling edge; returns at the falling edge after the block is idle again.
    task automatic write_line(input logic [63:0] addr, input logic [63:0] first,
                              input logic [63:0] step, input logic [11:0] tag12);
        int base;
        logic [63:0] d;
        base       = line_base_of(addr);
        bus_reqcyc = 1'b1;
        bus_req    = addr;
        bus_reqtag = {1'b0, tag12};
        @(negedge clk);
        check("w_ack", 64'(bus_reqack), 64'd1);
        bus_reqcyc = 1'b0;
        bus_req    = '0;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus_reqcyc = 1'b0;
                @(negedge clk);
            end
            check("w_ready", 64'(bus_reqack), 64'd1);
            d          = first + step * 64'(k);
            bus_reqcyc = 1'b1;
            bus_req    = d;
            model_mem[base + k] = d;
            @(negedge clk);
        end
        bus_reqcyc = 1'b0;
        bus_req    = '0;
        check("w_done", 64'(bus_reqack), 64'd0);
    endtask

    // ack_mode 0: respack always 1; 1: respack toggles 1,0,1,0.
    // abort: assert reset while the 3rd beat is presented.
    task automatic read_line(input logic [63:0] addr, input logic [11:0] tag12,
                             input int ack_mode, input bit abort);
        int base;
        int off;
        int cyc;
        int acked;
        int t;
        logic [TW-1:0] etag;
        base = line_base_of(addr);
`ifdef BUS_MEM_CRITICAL_WORD_FIRST_EN
        off = int'((addr >> 3) & 64'd7);
`else
        off = 0;
`endif
        for (int k = 0; k < 8; k++) exp_q.push_back(model_rd(base + ((off + k) & 7)));
        etag        = {1'b1, tag12};
        bus_reqcyc  = 1'b1;
        bus_req     = addr;
        bus_reqtag  = etag;
        bus_respack = (ack_mode == 0);
        @(negedge clk);
        check("r_ack", 64'(bus_reqack), 64'd1);
        bus_reqcyc = 1'b0;
        bus_req    = '0;
        cyc        = 1;
        while (!bus_respcyc && cyc < LAT + 12) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus_respcyc) begin
            check("r_timeout", 64'(bus_respcyc), 64'd1);
            exp_q.delete();
            bus_respack = 1'b0;
            return;
        end
        check("r_latency", 64'(cyc), 64'(LAT + 2));
        check("r_ack_low", 64'(bus_reqack), 64'd0);
        acked = 0;
        t     = 0;
        while (acked < 8 && t < 64) begin
            check("r_cyc", 64'(bus_respcyc), 64'd1);
            check("r_tag", 64'(bus_resptag), 64'(etag));
            check("r_data", bus_resp, exp_q[0]);
            if (abort && acked == 2) begin
                reset = 1'b0;
                @(negedge clk);
                check("abort_respcyc", 64'(bus_respcyc), 64'd0);
                check("abort_resp", bus_resp, 64'd0);
                check("abort_reqack", 64'(bus_reqack), 64'd0);
                reset       = 1'b1;
                bus_respack = 1'b0;
                exp_q.delete();
                return;
            end
            bus_respack = (ack_mode == 0) ? 1'b1 : ((t % 2) == 0);
            t++;
            if (bus_respack) begin
                void'(exp_q.pop_front());
                acked++;
            end
            @(negedge clk);
        end
        check("r_beats", 64'(acked), 64'd8);
        check("r_end", 64'(bus_respcyc), 64'd0);
        bus_respack = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        logic [63:0] a;
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b0;
        bus_reqcyc  = 1'b1;
        bus_req     = 64'h1000;
        bus_reqtag  = '0;
        bus_respack = 1'b1;

        // Reset held with request and respack asserted: nothing may happen.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_reqack", 64'(bus_reqack), 64'd0);
            check("rst_respcyc", 64'(bus_respcyc), 64'd0);
            check("rst_resp", bus_resp, 64'd0);
            check("rst_resptag", 64'(bus_resptag), 64'd0);
        end
        // Release with the request still up: taken on the very next edge.
        reset = 1'b1;
        write_line(64'h1000, 64'h11, 64'h11, 12'h001);
        bus_respack = 1'b0;

        read_line(64'h1000, 12'h5a5, 0, 1'b0);   // full-rate read
        read_line(64'h1000, 12'h123, 1, 1'b0);   // backpressure
        read_line(64'h1018, 12'h0f0, 0, 1'b0);   // critical word

        // Address wrap: 0x8000 maps to word 0.
        write_line(64'h8000, 64'hA000_0000_0000_0001, 64'h101, 12'h002);
        read_line(64'h0, 12'h3c3, 0, 1'b0);

        // Random lines and start words.
        for (int i = 0; i < 3; i++) begin
            a = 64'h2000 + 64'(64 * $urandom_range(0, 3));
            write_line(a, 64'({$urandom, $urandom}), 64'($urandom_range(1, 255)), 12'($urandom_range(0, 4095)));
            read_line(a + 64'(8 * $urandom_range(0, 7)), 12'($urandom_range(0, 4095)),
                      int'($urandom_range(0, 1)), 1'b0);
        end

        // Abort mid-read, then a clean read of the same line.
        read_line(64'h1000, 12'h777, 0, 1'b1);
        read_line(64'h1000, 12'h778, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
